// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, CPU read strobe and status of the UART receive FIFO
interface uart_rx_fifo_if;
  logic rxd;
  logic rd;
  logic err_clr;
  logic [7:0] q;
  logic ready;
  logic full;
  logic frame_err;
  logic overrun;
  modport master(output rxd, rd, err_clr, input q, ready, full, frame_err, overrun);
  modport slave(input rxd, rd, err_clr, output q, ready, full, frame_err, overrun);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled 8N1 UART receiver feeding a show-ahead byte FIFO
module uart_rx_fifo #(
  parameter int DIVISOR = 13,
  parameter int FIFO_AW = 2
) (
  input logic clk,
  input logic reset_n,
  input logic ce,
  uart_rx_fifo_if.slave bus
);
  localparam int TW = $clog2(DIVISOR);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic s1, rxs;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [3:0] s, s_n;
  logic [2:0] n, n_n;
  logic [7:0] sh, sh_n;
  logic tick, push, ferr_set, pop, wr, ovf, fe, ov;
  logic [7:0] mem [DEPTH];
  logic [7:0] q_r;
  logic [FIFO_AW-1:0] wptr, rptr, rptr_n;
  logic [FIFO_AW:0] cnt, cnt_pop;
  always_ff @(posedge clk)
    if (!reset_n) {s1, rxs} <= 2'b11;
    else if (ce) {s1, rxs} <= {bus.rxd, s1};
  assign tick = state != IDLE && tcnt == TW'(DIVISOR - 1);
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    sh_n = sh;
    push = 1'b0;
    ferr_set = 1'b0;
    tcnt_n = (state == IDLE || tick) ? '0 : tcnt + 1'b1;
    case (state)
      IDLE: if (!rxs) begin state_n = START; s_n = '0; end
      START: if (tick) begin
        s_n = s + 1'b1;
        if (s == 4'd7) begin state_n = rxs ? IDLE : DATA; s_n = '0; n_n = '0; end
      end
      DATA: if (tick) begin
        s_n = s + 1'b1;
        if (s == 4'd15) begin
          sh_n = {rxs, sh[7:1]};
          n_n = n + 1'b1;
          state_n = (n == 3'd7) ? STOP : DATA;
        end
      end
      STOP: if (tick) begin
        s_n = s + 1'b1;
        if (s == 4'd15) begin state_n = rxs ? IDLE : BRK; push = rxs; ferr_set = !rxs; end
      end
      BRK: state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      tcnt <= '0;
      s <= '0;
      n <= '0;
      sh <= '0;
    end else if (ce) begin
      state <= state_n;
      tcnt <= tcnt_n;
      s <= s_n;
      n <= n_n;
      sh <= sh_n;
    end
  // a full FIFO still accepts a byte when the CPU pops in the same cycle
  assign pop = bus.rd && cnt != 0;
  assign wr = push && (!cnt[FIFO_AW] || pop);
  assign ovf = push && cnt[FIFO_AW] && !pop;
  assign rptr_n = rptr + FIFO_AW'(pop);
  assign cnt_pop = cnt - (FIFO_AW + 1)'(pop);
  always_ff @(posedge clk)
    if (ce && wr) mem[wptr] <= sh;
  always_ff @(posedge clk)
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      q_r <= '0;
      fe <= 1'b0;
      ov <= 1'b0;
    end else if (ce) begin
      rptr <= rptr_n;
      wptr <= wptr + FIFO_AW'(wr);
      cnt <= cnt_pop + (FIFO_AW + 1)'(wr);
      q_r <= (cnt_pop == 0) ? (wr ? sh : q_r) : mem[rptr_n];
      fe <= ferr_set || (fe && !bus.err_clr);
      ov <= ovf || (ov && !bus.err_clr);
    end
  assign bus.q = q_r;
  assign bus.ready = cnt != 0;
  assign bus.full = cnt[FIFO_AW];
  assign bus.frame_err = fe;
  assign bus.overrun = ov;
endmodule
